// File: rtl/mod_seq_pkg.sv
// Shared types for the modulo counter sequencer: FSM state encoding and
// the width of the optional wrap counter.
package mod_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam int WRAP_COUNT_W = 8;

endpackage

// File: rtl/mod_counter_core.sv
// Modulo-N counter register: clear > load > enable.
// A load beyond MODULUS-1 saturates at MODULUS-1.
// Enabled increments wrap from MODULUS-1 back to 0.
module mod_counter_core #(
  parameter int MODULUS = 13,
  parameter int WIDTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_value,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;

  // next count: clear, saturating load, or wrapping increment
  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (ld) count_d = (ld_value > MAX) ? MAX : ld_value;
    else if (en) count_d = (count_q == MAX) ? '0 : count_q + WIDTH'(1);
  end

  // count register, async reset to 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX);

endmodule

// File: rtl/mod_counter_sequencer.sv
// Run/hold/abort/load/one-shot sequencer around a modulo-N counter.
// Command priority each cycle: load > stop > start.
// Optional macro SEQ_WRAP_COUNT_EN adds a saturating 8-bit wrap counter
// output (wrap_count).
module mod_counter_sequencer
  import mod_seq_pkg::*;
#(
  parameter int MODULUS = 13,
  parameter int WIDTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             one_shot,
`ifdef SEQ_WRAP_COUNT_EN
  output logic [WRAP_COUNT_W-1:0] wrap_count,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  seq_state_e state_q, state_d;
  logic       cnt_en, cnt_clr, cnt_ld, at_max;
  logic       wc_clr, wc_inc;

  mod_counter_core #(.MODULUS(MODULUS), .WIDTH(WIDTH)) u_core (
    .clock    (clock),
    .reset    (reset),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .ld       (cnt_ld),
    .ld_value (load_value),
    .count    (count),
    .at_max   (at_max)
  );

  // command decode and next-state logic
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    cnt_ld  = 1'b0;
    wc_clr  = 1'b0;
    wc_inc  = 1'b0;
    if (load) begin
      // load never changes state and suppresses the increment
      cnt_ld = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stop) cnt_clr = 1'b1;
          else if (start) begin
            state_d = RUN;
            wc_clr  = 1'b1;
          end
        end
        RUN: begin
          if (stop) state_d = HOLD;
          else begin
            cnt_en = 1'b1;
            if (at_max) begin
              wc_inc = 1'b1;
              if (one_shot) state_d = DONE;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            wc_clr  = 1'b1;
          end else if (start) state_d = RUN;
        end
        DONE: begin
          if (stop) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else if (start) begin
            state_d = RUN;
            cnt_clr = 1'b1;
            wc_clr  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state register, async reset to IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign tc   = (state_q == RUN) && at_max;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef SEQ_WRAP_COUNT_EN
  logic [WRAP_COUNT_W-1:0] wrap_q;

  // wrap counter: saturates at all-ones, clear wins over increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       wrap_q <= '0;
    else if (wc_clr)                 wrap_q <= '0;
    else if (wc_inc && ~&wrap_q)     wrap_q <= wrap_q + 1'b1;
  end

  assign wrap_count = wrap_q;
`else
  logic unused_wc;
  assign unused_wc = wc_clr ^ wc_inc;
`endif

endmodule

// File: tb/tb_mod_counter_sequencer.sv
// Directed bench for mod_counter_sequencer (MODULUS=13, WIDTH=4).
module tb_mod_counter_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, stop = 1'b0, load = 1'b0, one_shot = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] count;
  logic       tc, busy, done;
`ifdef SEQ_WRAP_COUNT_EN
  logic [7:0] wrap_count;
`endif

  int checks = 0;
  int errors = 0;

  mod_counter_sequencer #(.MODULUS(13), .WIDTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .load       (load),
    .load_value (load_value),
    .one_shot   (one_shot),
`ifdef SEQ_WRAP_COUNT_EN
    .wrap_count (wrap_count),
`endif
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // advance one edge and settle
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d tc=%b busy=%b done=%b, want 0/0/0/0", count, tc, busy, done);
    end
`ifdef SEQ_WRAP_COUNT_EN
    checks++;
    if (wrap_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_wrap: wrap_count=%0d want 0", wrap_count);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  // abort back to IDLE from RUN: RUN->HOLD->IDLE
  task automatic abort_to_idle();
    stop = 1'b1; tick(); tick(); stop = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: count=%0d busy=%b done=%b, want 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_free_run();
    int exp_cnt;
    one_shot = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    exp_cnt = 0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: count=%0d busy=%b, want 0/1", count, busy);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_cnt = (exp_cnt + 1) % 13;
      checks++;
      if (count !== 4'(exp_cnt) || tc !== (exp_cnt == 12) || busy !== 1'b1) begin
        errors++;
        $display("FAIL free_run[%0d]: count=%0d tc=%b busy=%b, want %0d/%b/1",
                 i, count, tc, busy, exp_cnt, (exp_cnt == 12));
      end
    end
    abort_to_idle();
  endtask

  task automatic test_one_shot();
    one_shot = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (count !== 4'(i) || tc !== (i == 12) || busy !== 1'b1) begin
        errors++;
        $display("FAIL one_shot_run[%0d]: count=%0d tc=%b busy=%b", i, count, tc, busy);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== 4'd0 || done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL one_shot_done[%0d]: count=%0d done=%b busy=%b tc=%b, want 0/1/0/0",
                 i, count, done, busy, tc);
      end
    end
    one_shot = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_restart: count=%0d busy=%b done=%b, want 0/1/0", count, busy, done);
    end
    tick();
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL done_restart_inc: count=%0d want 1", count);
    end
    abort_to_idle();
  endtask

  task automatic test_hold();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if (count !== 4'd5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_enter: count=%0d busy=%b, want 5/0", count, busy);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (count !== 4'd5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_stay: count=%0d busy=%b, want 5/0", count, busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resume: count=%0d busy=%b, want 5/1", count, busy);
    end
    tick();
    checks++;
    if (count !== 4'd6) begin
      errors++;
      $display("FAIL resume_inc: count=%0d want 6", count);
    end
    abort_to_idle();
  endtask

  task automatic test_load();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    load = 1'b1; load_value = 4'd9; tick(); load = 1'b0;
    checks++;
    if (count !== 4'd9 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load9: count=%0d busy=%b, want 9/1", count, busy);
    end
    tick();
    checks++;
    if (count !== 4'd10) begin
      errors++;
      $display("FAIL load_inc: count=%0d want 10", count);
    end
    load = 1'b1; load_value = 4'd15; tick(); load = 1'b0;
    checks++;
    if (count !== 4'd12 || tc !== 1'b1) begin
      errors++;
      $display("FAIL load_sat: count=%0d tc=%b, want 12/1", count, tc);
    end
    tick();
    checks++;
    if (count !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_wrap: count=%0d busy=%b, want 0/1", count, busy);
    end
    abort_to_idle();
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1; tick();
    checks++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL both_idle: count=%0d busy=%b, want 0/0", count, busy);
    end
    stop = 1'b0; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; stop = 1'b1; tick();
    checks++;
    if (count !== 4'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL both_run: count=%0d busy=%b, want 2/0", count, busy);
    end
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL both_hold: count=%0d busy=%b, want 0/0", count, busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    load = 1'b1; stop = 1'b1; load_value = 4'd4; tick(); load = 1'b0; stop = 1'b0;
    checks++;
    if (count !== 4'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_stop: count=%0d busy=%b, want 4/1", count, busy);
    end
    tick();
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL load_stop_inc: count=%0d want 5", count);
    end
    abort_to_idle();
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL pre_reset: count=%0d want 7", count);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d busy=%b tc=%b, want 0/0/0", count, busy, tc);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: count=%0d busy=%b, want 0/0", count, busy);
    end
  endtask

`ifdef SEQ_WRAP_COUNT_EN
  task automatic test_wrap_count();
    one_shot = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 26; i++) tick();
    checks++;
    if (wrap_count !== 8'd2 || count !== 4'd0) begin
      errors++;
      $display("FAIL wrap2: wrap_count=%0d count=%0d, want 2/0", wrap_count, count);
    end
    one_shot = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    one_shot = 1'b0;
    checks++;
    if (wrap_count !== 8'd3 || done !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL wrap3: wrap_count=%0d done=%b count=%0d, want 3/1/0", wrap_count, done, count);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if (wrap_count !== 8'd3 || done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_keep: wrap_count=%0d done=%b, want 3/0", wrap_count, done);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (wrap_count !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_clr: wrap_count=%0d busy=%b, want 0/1", wrap_count, busy);
    end
    abort_to_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_one_shot();
    test_hold();
    test_load();
    test_start_stop();
    test_async_reset();
`ifdef SEQ_WRAP_COUNT_EN
    test_wrap_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
